// File: rtl/vga_text_writer.sv
// vga_text_writer
// Writer side of the VGA character buffer. Takes a byte stream over a
// valid/ready handshake, keeps a text cursor and turns printable bytes into
// single-cycle writes to the dual-port char RAM at row*COLS + col. CR, LF and
// backspace move the cursor. A full-page clear fills the page with BLANK.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   char_in     in   incoming byte
//   char_valid  in   char_in is valid
//   char_ready  out  byte accepted this cycle when char_valid is also high
//   clear_req   in   full-page clear request (level, sampled in IDLE)
//   mem_we      out  char RAM write enable, registered single-cycle pulse
//   mem_addr    out  char RAM write address, registered
//   mem_wdata   out  char RAM write data, registered
//   cursor_col  out  current column 0..COLS-1, registered
//   cursor_row  out  current row 0..ROWS-1, registered
//   busy        out  high while the clear sequence runs
module vga_text_writer #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 25,
    parameter int          ADDR_W = 11,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic [ADDR_W-1:0] cursor_addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        wdata_nxt;
    logic [6:0]        col_nxt;
    logic [4:0]        row_nxt;
    logic              we_nxt;
    logic              busy_nxt;
    logic              accept;

    // A pending clear blocks the byte so the source keeps holding it.
    assign char_ready  = (state == IDLE) && !clear_req;
    assign accept      = char_valid && char_ready;
    assign cursor_addr = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);

    // State register plus every registered output and the clear counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            clr_cnt    <= clr_cnt_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state logic: clear is entered from IDLE and left after the last cell.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clear_req) next_state = CLEAR;
            CLEAR:   if (clr_cnt == LAST_A) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: computes the values the output registers take next cycle.
    // busy also covers the cycle that presents the final clear write, which is
    // registered one cycle after the FSM has already returned to IDLE.
    always_comb begin
        we_nxt      = 1'b0;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        col_nxt     = cursor_col;
        row_nxt     = cursor_row;
        clr_cnt_nxt = clr_cnt;
        busy_nxt    = (next_state == CLEAR) || (state == CLEAR);
        case (state)
            IDLE: begin
                if (clear_req) begin
                    clr_cnt_nxt = '0;
                end else if (accept) begin
                    if (char_in >= 8'h20 && char_in <= 8'h7E) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = cursor_addr;
                        wdata_nxt = char_in;
                        if (cursor_col == LAST_COL) begin
                            col_nxt = '0;
                            row_nxt = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
                        end else begin
                            col_nxt = cursor_col + 7'd1;
                        end
                    end else if (char_in == 8'h0D) begin
                        col_nxt = '0;
                    end else if (char_in == 8'h0A) begin
                        col_nxt = '0;
                        row_nxt = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
                    end else if (char_in == 8'h08) begin
                        // Backspace stays on the current row; blank the cell it lands on.
                        if (cursor_col != 7'd0) begin
                            col_nxt   = cursor_col - 7'd1;
                            we_nxt    = 1'b1;
                            addr_nxt  = cursor_addr - ADDR_W'(1);
                            wdata_nxt = BLANK;
                        end
                    end
                end
            end
            CLEAR: begin
                we_nxt    = 1'b1;
                addr_nxt  = clr_cnt;
                wdata_nxt = BLANK;
                if (clr_cnt == LAST_A) begin
                    col_nxt = '0;
                    row_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer
// Drives vga_text_writer with directed and random byte streams. A reference
// model tracks the cursor as a linear page position and queues the RAM writes
// it expects; a monitor on the falling edge pops and compares every write.
module tb_vga_text_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    typedef struct {
        int         addr;
        logic [7:0] data;
        bit         busy;
    } wr_t;

    wr_t sb[$];
    int  tests_run = 0;
    int  tests_failed = 0;
    int  exp_col = 0;
    int  exp_row = 0;

    vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(11), .BLANK(8'h20)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Hard stop if something hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: the cursor is a position on a 2000-cell page.
    task automatic modelAccept(input logic [7:0] b);
        int pos;
        if (b >= 8'h20 && b <= 8'h7E) begin
            sb.push_back('{addr: exp_row * COLS + exp_col, data: b, busy: 1'b0});
            pos = (exp_row * COLS + exp_col + 1) % CELLS;
            exp_col = pos % COLS;
            exp_row = pos / COLS;
        end else if (b == 8'h0D) begin
            exp_col = 0;
        end else if (b == 8'h0A) begin
            exp_col = 0;
            exp_row = (exp_row + 1) % ROWS;
        end else if (b == 8'h08) begin
            if (exp_col > 0) begin
                exp_col = exp_col - 1;
                sb.push_back('{addr: exp_row * COLS + exp_col, data: 8'h20, busy: 1'b0});
            end
        end
    endtask

    task automatic pushClear();
        for (int k = 0; k < CELLS; k++)
            sb.push_back('{addr: k, data: 8'h20, busy: 1'b1});
    endtask

    // Monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write_addr", int'(mem_addr), -1);
            end else begin
                wr_t e;
                e = sb.pop_front();
                checkOutput("wr_addr", int'(mem_addr), e.addr);
                checkOutput("wr_data", int'(mem_wdata), int'(e.data));
                checkOutput("wr_busy", int'(busy), int'(e.busy));
            end
        end
    end

    // Presents one byte starting at a falling edge; returns at the falling
    // edge after acceptance with the cursor checked.
    task automatic applyStimulus(input logic [7:0] b);
        int waited = 0;
        bit acc = 1'b0;
        char_in = b;
        char_valid = 1'b1;
        while (!acc && waited < 3000) begin
            #1;
            acc = char_ready;
            @(posedge clk);
            if (!acc) begin
                waited++;
                @(negedge clk);
            end
        end
        if (!acc) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            modelAccept(b);
        end
        @(negedge clk);
        char_valid = 1'b0;
        checkOutput("cursor_col", int'(cursor_col), exp_col);
        checkOutput("cursor_row", int'(cursor_row), exp_row);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_col = 0;
        exp_row = 0;
        checkOutput("rst_mem_we", int'(mem_we), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_col", int'(cursor_col), 0);
        checkOutput("rst_row", int'(cursor_row), 0);
    endtask

    initial begin
        logic [7:0] b;
        int waited;

        // Power-on reset.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mem_we", int'(mem_we), 0);
        checkOutput("rst_mem_addr", int'(mem_addr), 0);
        checkOutput("rst_mem_wdata", int'(mem_wdata), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_col", int'(cursor_col), 0);
        checkOutput("rst_row", int'(cursor_row), 0);
        checkOutput("rst_ready", int'(char_ready), 1);

        // Single printable char.
        applyStimulus(8'h41);

        // 81 chars back to back across the first row boundary.
        doReset();
        for (int i = 0; i < 81; i++) applyStimulus(8'(8'h30 + (i % 40)));

        // Bottom-right corner wrap, then LF wrap from the last row.
        doReset();
        for (int i = 0; i < 24; i++) applyStimulus(8'h0A);
        for (int i = 0; i < 79; i++) applyStimulus(8'h61);
        checkOutput("corner_col", int'(cursor_col), 79);
        checkOutput("corner_row", int'(cursor_row), 24);
        applyStimulus(8'h5A);
        for (int i = 0; i < 24; i++) applyStimulus(8'h0A);
        applyStimulus(8'h0A);

        // Backspace mid-row and at column 0.
        doReset();
        applyStimulus(8'h0A);
        applyStimulus(8'h0A);
        for (int i = 0; i < 5; i++) applyStimulus(8'h62);
        applyStimulus(8'h08);
        applyStimulus(8'h0D);
        applyStimulus(8'h08);

        // Random mix of printable, control and junk bytes with gaps.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                6:       b = 8'h0D;
                7:       b = 8'h0A;
                8:       b = 8'h08;
                9:       b = 8'($urandom_range(0, 255));
                default: b = 8'($urandom_range(32, 126));
            endcase
            applyStimulus(b);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Clear requested together with a byte: clear wins, byte waits.
        char_in = 8'h51;
        char_valid = 1'b1;
        clear_req = 1'b1;
        #1;
        checkOutput("clear_blocks_ready", int'(char_ready), 0);
        @(posedge clk);
        pushClear();
        #1;
        clear_req = 1'b0;
        @(negedge clk);
        checkOutput("clear_busy", int'(busy), 1);
        checkOutput("clear_ready", int'(char_ready), 0);
        waited = 0;
        while (!char_ready && waited < 2100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("clear_done_ready", int'(char_ready), 1);
        exp_col = 0;
        exp_row = 0;
        checkOutput("clear_col", int'(cursor_col), 0);
        checkOutput("clear_row", int'(cursor_row), 0);
        @(posedge clk);
        modelAccept(8'h51);
        @(negedge clk);
        char_valid = 1'b0;
        checkOutput("held_col", int'(cursor_col), exp_col);
        checkOutput("busy_after_clear", int'(busy), 0);

        // Reset while the clear counter is at 500.
        applyStimulus(8'h63);
        clear_req = 1'b1;
        @(posedge clk);
        pushClear();
        #1;
        clear_req = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_remaining", sb.size(), CELLS - 500);
        sb.delete();
        rst = 1'b0;
        exp_col = 0;
        exp_row = 0;
        checkOutput("abort_mem_we", int'(mem_we), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_col", int'(cursor_col), 0);
        checkOutput("abort_row", int'(cursor_row), 0);
        checkOutput("abort_ready", int'(char_ready), 1);
        applyStimulus(8'h07);

        // Drain and confirm nothing expected is left over.
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
